// File: rtl/timer_pkg.sv
// Shared widths and active-low seven-segment glyphs for the multi-digit timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  // Patterns are gfedcba, segment a in bit 0, a 0 lights the segment.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Clamp a BCD digit into 0..9; codes A..F become 9.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-low seven-segment pattern; non-decimal codes blank.
module bcd_to_7seg
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   seg_o
);

  // Pure lookup, no state.
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_timer.sv
// Parameterised BCD up/down timer with prescaler, wrap/stop terminal handling
// and per-digit seven-segment decode of the registered count.
module multi_digit_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          direction,
  input  logic                          mode,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic [SEG_W*NUM_DIGITS-1:0]   seg,
  output logic                          tc,
  output logic                          done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = DIGIT_W * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         step_cnt;
  logic [CW-1:0]         load_sat;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS-1:0] dig_nine, dig_zero;
  logic                  tick, at_term;

  assign tick     = start && (presc_q == PW'(TICK_DIV - 1));
  assign carry[0] = 1'b1;

  // Ripple chain: a digit steps only when every lower digit rolled over, so
  // the all-9/all-0 wrap falls out of the same chain with no special case.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    assign d           = cnt_q[i*DIGIT_W +: DIGIT_W];
    assign dig_nine[i] = (d == 4'd9);
    assign dig_zero[i] = (d == 4'd0);
    assign step_cnt[i*DIGIT_W +: DIGIT_W] =
        !carry[i] ? d :
        direction ? (dig_nine[i] ? 4'd0 : d + 4'd1) :
                    (dig_zero[i] ? 4'd9 : d - 4'd1);
    assign carry[i+1] = carry[i] & (direction ? dig_nine[i] : dig_zero[i]);
    assign load_sat[i*DIGIT_W +: DIGIT_W] = sat_digit(load_value[i*DIGIT_W +: DIGIT_W]);

    bcd_to_7seg u_seg (
      .digit_i (d),
      .seg_o   (seg[i*SEG_W +: SEG_W])
    );
  end

  assign at_term = direction ? (&dig_nine) : (&dig_zero);

  // Next-state: load beats tick; with start low everything holds and tc stays 0.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = load_sat;
      presc_d = '0;
      done_d  = 1'b0;
    end else if (start) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (at_term && mode) begin
          done_d = 1'b1;
          tc_d   = !done_q;
        end else begin
          cnt_d  = step_cnt;
          done_d = 1'b0;
          tc_d   = at_term;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = cnt_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_multi_digit_timer.sv
// Directed bench: a 2-digit/div-1 timer and a 3-digit/div-4 timer on one clock.
module tb_multi_digit_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2 digits, TICK_DIV = 1
  logic        reset, start, direction, mode, load;
  logic [7:0]  load_value, bcd;
  logic [13:0] seg;
  logic        tc, done;

  // 3 digits, TICK_DIV = 4
  logic        reset3, start3, direction3, mode3, load3;
  logic [11:0] load_value3, bcd3;
  logic [20:0] seg3;
  logic        tc3, done3;

  multi_digit_timer #(.NUM_DIGITS(2), .TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .direction(direction), .mode(mode),
    .load(load), .load_value(load_value), .bcd(bcd), .seg(seg), .tc(tc), .done(done)
  );

  multi_digit_timer #(.NUM_DIGITS(3), .TICK_DIV(4)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .direction(direction3), .mode(mode3),
    .load(load3), .load_value(load_value3), .bcd(bcd3), .seg(seg3), .tc(tc3), .done(done3)
  );

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; direction = 1'b0; mode = 1'b0; load = 1'b0;
    load_value = '0;
    reset3 = 1'b0; start3 = 1'b0; direction3 = 1'b0; mode3 = 1'b0; load3 = 1'b0;
    load_value3 = '0;

    // Reset state
    cyc(2);
    check("rst_bcd",  32'(bcd),  32'h0);
    check("rst_seg",  32'(seg),  32'({7'h40, 7'h40}));
    check("rst_tc",   32'(tc),   32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Count up with wrap, tc only on 99 -> 00
    reset = 1'b1; start = 1'b1; direction = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      check("up_bcd", 32'(bcd), 32'(to_bcd2(i % 100)));
      check("up_tc",  32'(tc),  32'(i == 100));
    end
    cyc(1);
    check("up_after_wrap_bcd", 32'(bcd), 32'h01);
    check("up_after_wrap_tc",  32'(tc),  32'h0);

    // Load 05, count down in stop mode, then reverse
    load_value = 8'h05; direction = 1'b0; mode = 1'b1; load = 1'b1;
    cyc(1);
    check("dn_load_bcd", 32'(bcd), 32'h05);
    load = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      cyc(1);
      check("dn_bcd",  32'(bcd),  32'(to_bcd2(i)));
      check("dn_tc",   32'(tc),   32'h0);
      check("dn_done", 32'(done), 32'h0);
    end
    cyc(1);
    check("stop_bcd",  32'(bcd),  32'h00);
    check("stop_done", 32'(done), 32'h1);
    check("stop_tc",   32'(tc),   32'h1);
    cyc(2);
    check("stop_hold_bcd",  32'(bcd),  32'h00);
    check("stop_hold_done", 32'(done), 32'h1);
    check("stop_hold_tc",   32'(tc),   32'h0);
    direction = 1'b1;
    cyc(1);
    check("rev_bcd",  32'(bcd),  32'h01);
    check("rev_done", 32'(done), 32'h0);
    check("rev_tc",   32'(tc),   32'h0);

    // Pause, then reset mid-count
    load_value = 8'h37; load = 1'b1;
    cyc(1);
    load = 1'b0; start = 1'b0;
    cyc(10);
    check("pause_bcd", 32'(bcd), 32'h37);
    check("pause_tc",  32'(tc),  32'h0);
    start = 1'b1;
    cyc(3);
    check("resume_bcd", 32'(bcd), 32'h40);
    reset = 1'b0;
    cyc(2);
    check("midrst_bcd",  32'(bcd),  32'h00);
    check("midrst_seg",  32'(seg),  32'({7'h40, 7'h40}));
    check("midrst_done", 32'(done), 32'h0);
    reset = 1'b1;

    // Saturating load, load beats a concurrent tick, load clears done
    load_value = 8'hFA; load = 1'b1;
    cyc(1);
    check("sat_FA", 32'(bcd), 32'h99);
    load_value = 8'h3C;
    cyc(1);
    check("sat_3C", 32'(bcd), 32'h39);
    load_value = 8'h99; mode = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("up_stop_bcd",  32'(bcd),  32'h99);
    check("up_stop_done", 32'(done), 32'h1);
    check("up_stop_tc",   32'(tc),   32'h1);
    load_value = 8'h12; load = 1'b1;
    cyc(1);
    check("ld_clr_bcd",  32'(bcd),  32'h12);
    check("ld_clr_done", 32'(done), 32'h0);
    check("ld_clr_tc",   32'(tc),   32'h0);
    load = 1'b0; mode = 1'b0;

    // Segment sweep, each value on each digit position
    start = 1'b0;
    for (int v = 0; v < 10; v++) begin
      load_value = {4'(v), 4'(9 - v)}; load = 1'b1;
      cyc(1);
      check("sweep_seg", 32'(seg), 32'({seg_tab[v], seg_tab[9 - v]}));
    end
    load = 1'b0;

    // 3 digits, TICK_DIV=4: 998 -> 999 -> 000 with full carry
    reset3 = 1'b1; load_value3 = 12'h998; load3 = 1'b1;
    cyc(1);
    check("d3_load", 32'(bcd3), 32'h998);
    load3 = 1'b0; start3 = 1'b1; direction3 = 1'b1; mode3 = 1'b0;
    cyc(3);
    check("d3_hold3", 32'(bcd3), 32'h998);
    cyc(1);
    check("d3_999",    32'(bcd3), 32'h999);
    check("d3_999_tc", 32'(tc3),  32'h0);
    cyc(3);
    check("d3_999_hold", 32'(bcd3), 32'h999);
    cyc(1);
    check("d3_wrap_bcd", 32'(bcd3), 32'h000);
    check("d3_wrap_tc",  32'(tc3),  32'h1);
    check("d3_wrap_seg", 32'(seg3), 32'({7'h40, 7'h40, 7'h40}));
    cyc(1);
    check("d3_tc_drop", 32'(tc3), 32'h0);

    // Reset mid-phase discards prescaler progress
    cyc(1);
    reset3 = 1'b0;
    cyc(1);
    reset3 = 1'b1;
    cyc(3);
    check("d3_rst_phase", 32'(bcd3), 32'h000);
    cyc(1);
    check("d3_rst_tick", 32'(bcd3), 32'h001);

    // Down wrap 000 -> 999 in wrap mode
    direction3 = 1'b0;
    cyc(4);
    check("d3_dn_000", 32'(bcd3), 32'h000);
    check("d3_dn_tc0", 32'(tc3),  32'h0);
    cyc(4);
    check("d3_dn_wrap", 32'(bcd3), 32'h999);
    check("d3_dn_tc",   32'(tc3),  32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
